img_sobel_pipe: RTL and testbench

Parametrised successor to the camera-path image processor. Takes the raw Bayer stream from the CCD capture block, builds one greyscale pixel per 2x2 Bayer quad, and applies a 3x3 Sobel kernel selected per frame. The selectable kernel modes are bypass, |Gx|, |Gy| and |Gx|+|Gy|. Drives the same grey value on oRed/oGreen/oBlue, with oDVAL cycle-aligned to the data, toward the SDRAM write path.

---
 rtl/img_pkg.sv | 21 ++
 rtl/img_line_buffer.sv | 25 ++
 rtl/img_sobel_pipe.sv | 155 +++++++++++++++
 tb/tb_img_sobel_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and helpers for the greyscale Sobel camera pipeline.
package img_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GX     = 2'd1,
    MODE_GY     = 2'd2,
    MODE_MAG    = 2'd3
  } mode_e;

  // Sobel weights expressed as left shifts: side taps x1, centre taps x2.
  localparam int unsigned SOBEL_SIDE_SHIFT   = 0;
  localparam int unsigned SOBEL_CENTRE_SHIFT = 1;

  function automatic logic [31:0] sat_u(input logic [31:0] value, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    return (value > maxVal) ? maxVal : value;
  endfunction

endpackage

// File: rtl/img_line_buffer.sv
// Clock-enabled shift RAM; tap returns the word written DEPTH enables ago.
module img_line_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             clken,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clken) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign tap = mem[DEPTH-1];

endmodule

// File: rtl/img_sobel_pipe.sv
// Bayer quad -> grey pixel -> 3x3 window -> Sobel/bypass, one output per grey pixel.
module img_sobel_pipe
  import img_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int X_W      = 11,
  parameter int RAW_W    = 1280,
  parameter int RST_MODE = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [X_W-1:0]    iX_Cont,
  input  logic [X_W-1:0]    iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL
);

  localparam int GW = RAW_W / 2;
  localparam int SW = DATA_W + 2;
  localparam int KW = DATA_W + 4;
  localparam int MW = KW + 1;
  localparam mode_e RESET_MODE = mode_e'(2'(RST_MODE));

  logic [DATA_W-1:0] rawTap, prevTap, prevPix;
  logic [DATA_W-1:0] grey, tap1, tap2;
  logic [SW-1:0]     quadSum;
  logic              quadDone, frameStart, greyV, winV, border;
  logic [X_W-1:0]    s1Gx, s1Gy, s2Gx, s2Gy;
  mode_e             modeQ, s1Mode, s2Mode;
  logic [DATA_W-1:0] win [3][3];
  logic signed [KW-1:0] sobelX, sobelY;
  logic [KW-1:0]     absX, absY;
  logic [MW-1:0]     magVal;
  logic [DATA_W-1:0] pixNext, pixOut;

  function automatic logic signed [KW-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  img_line_buffer #(.DEPTH(RAW_W), .WIDTH(DATA_W)) rawLine (
    .clock(iCLK), .clken(iDVAL), .din(iDATA), .tap(rawTap)
  );

  // Quad completes on the B pixel; the other three come from the previous pixel and raw row taps.
  assign quadDone   = iDVAL & iX_Cont[0] & iY_Cont[0];
  assign frameStart = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
  assign quadSum    = SW'(iDATA) + SW'(prevPix) + SW'(rawTap) + SW'(prevTap);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      greyV   <= 1'b0;
      grey    <= '0;
      s1Gx    <= '0;
      s1Gy    <= '0;
      s1Mode  <= RESET_MODE;
      modeQ   <= RESET_MODE;
      prevPix <= '0;
      prevTap <= '0;
    end else begin
      greyV <= quadDone;
      if (iDVAL) begin
        prevPix <= iDATA;
        prevTap <= rawTap;
      end
      if (frameStart) modeQ <= mode_e'(iMODE);
      if (quadDone) begin
        grey   <= quadSum[SW-1:2];
        s1Gx   <= iX_Cont >> 1;
        s1Gy   <= iY_Cont >> 1;
        s1Mode <= modeQ;
      end
    end
  end

  img_line_buffer #(.DEPTH(GW), .WIDTH(DATA_W)) greyRow1 (
    .clock(iCLK), .clken(greyV), .din(grey), .tap(tap1)
  );

  img_line_buffer #(.DEPTH(GW), .WIDTH(DATA_W)) greyRow2 (
    .clock(iCLK), .clken(greyV), .din(tap1), .tap(tap2)
  );

  // Row 0 is the oldest grey line, column 2 the newest pixel.
  always_ff @(posedge iCLK) begin
    if (greyV) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= tap2;
      win[1][2] <= tap1;
      win[2][2] <= grey;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      winV   <= 1'b0;
      s2Gx   <= '0;
      s2Gy   <= '0;
      s2Mode <= RESET_MODE;
    end else begin
      winV <= greyV;
      if (greyV) begin
        s2Gx   <= s1Gx;
        s2Gy   <= s1Gy;
        s2Mode <= s1Mode;
      end
    end
  end

  assign sobelX = ((ext(win[0][2]) <<< SOBEL_SIDE_SHIFT) + (ext(win[1][2]) <<< SOBEL_CENTRE_SHIFT)
                 + (ext(win[2][2]) <<< SOBEL_SIDE_SHIFT))
                - ((ext(win[0][0]) <<< SOBEL_SIDE_SHIFT) + (ext(win[1][0]) <<< SOBEL_CENTRE_SHIFT)
                 + (ext(win[2][0]) <<< SOBEL_SIDE_SHIFT));
  assign sobelY = ((ext(win[2][0]) <<< SOBEL_SIDE_SHIFT) + (ext(win[2][1]) <<< SOBEL_CENTRE_SHIFT)
                 + (ext(win[2][2]) <<< SOBEL_SIDE_SHIFT))
                - ((ext(win[0][0]) <<< SOBEL_SIDE_SHIFT) + (ext(win[0][1]) <<< SOBEL_CENTRE_SHIFT)
                 + (ext(win[0][2]) <<< SOBEL_SIDE_SHIFT));
  assign absX   = sobelX[KW-1] ? $unsigned(-sobelX) : $unsigned(sobelX);
  assign absY   = sobelY[KW-1] ? $unsigned(-sobelY) : $unsigned(sobelY);
  assign border = (s2Gx < X_W'(2)) || (s2Gy < X_W'(2));

  always_comb begin
    magVal = '0;
    case (s2Mode)
      MODE_BYPASS: magVal = {5'b00000, win[1][1]};
      MODE_GX:     magVal = {1'b0, absX};
      MODE_GY:     magVal = {1'b0, absY};
      MODE_MAG:    magVal = {1'b0, absX} + {1'b0, absY};
      default:     magVal = '0;
    endcase
    pixNext = border ? '0 : DATA_W'(sat_u(32'(magVal), DATA_W));
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL  <= 1'b0;
      pixOut <= '0;
    end else begin
      oDVAL <= winV;
      if (winV) pixOut <= pixNext;
    end
  end

  assign oRed   = pixOut;
  assign oGreen = pixOut;
  assign oBlue  = pixOut;

endmodule

// File: tb/tb_img_sobel_pipe.sv
// Randomised frame-level bench for img_sobel_pipe with an image-domain Sobel reference model.
module tb_img_sobel_pipe;

  logic        iCLK;
  logic        iRST;
  logic [10:0] iX_Cont, iY_Cont;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [1:0]  iMODE;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL;

  img_sobel_pipe #(.DATA_W(12), .X_W(11), .RAW_W(8), .RST_MODE(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iDATA(iDATA),
    .iDVAL(iDVAL), .iMODE(iMODE), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int rawImg [8][8];
  int dutOut [4][4];
  int expVal[$], expCyc[$], expGx[$], expGy[$];
  int seqOut[$], seqRef[$];
  int errors = 0, checks = 0;
  int modelMode = 2, pulseCount = 0, lastExp = 0;
  bit monitorOn = 0, pushExp = 1;

  // Reference model: grey image from the raw frame, then a plain 3x3 Sobel on grey coordinates.
  function automatic int greyAt(int gx, int gy);
    return (rawImg[2*gy][2*gx] + rawImg[2*gy][2*gx+1] + rawImg[2*gy+1][2*gx] + rawImg[2*gy+1][2*gx+1]) / 4;
  endfunction

  function automatic int expectedOut(int gx, int gy, int mode);
    int g [3][3];
    int sx, sy, r;
    if (gx < 2 || gy < 2) return 0;
    for (int row = 0; row < 3; row++)
      for (int col = 0; col < 3; col++)
        g[row][col] = greyAt(gx - 2 + col, gy - 2 + row);
    sx = (g[0][2] + 2*g[1][2] + g[2][2]) - (g[0][0] + 2*g[1][0] + g[2][0]);
    sy = (g[2][0] + 2*g[2][1] + g[2][2]) - (g[0][0] + 2*g[0][1] + g[0][2]);
    if (sx < 0) sx = -sx;
    if (sy < 0) sy = -sy;
    case (mode)
      0: r = g[1][1];
      1: r = sx;
      2: r = sy;
      default: r = sx + sy;
    endcase
    return (r > 4095) ? 4095 : r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge iCLK) begin
    if (monitorOn && iRST) begin
      if (oDVAL) begin
        if (expVal.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra oDVAL: got pulse, want none (cycle %0d)", cyc);
        end else begin
          int v, c, gx, gy;
          v = expVal.pop_front();
          c = expCyc.pop_front();
          gx = expGx.pop_front();
          gy = expGy.pop_front();
          checkOutput("oRed", int'(oRed), v);
          checkOutput("oGreen", int'(oGreen), v);
          checkOutput("oBlue", int'(oBlue), v);
          checkOutput("latency", cyc - c, 3);
          dutOut[gy][gx] = int'(oRed);
          seqOut.push_back(int'(oRed));
          lastExp = v;
          pulseCount++;
        end
      end else begin
        checkOutput("hold oRed", int'(oRed), lastExp);
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input int mode);
    @(posedge iCLK);
    #1;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iDATA   = 12'(rawImg[y][x]);
    iDVAL   = 1'b1;
    iMODE   = 2'(mode);
    if (pushExp && (x % 2 == 1) && (y % 2 == 1)) begin
      expVal.push_back(expectedOut(x / 2, y / 2, modelMode));
      expCyc.push_back(cyc);
      expGx.push_back(x / 2);
      expGy.push_back(y / 2);
    end
  endtask

  task automatic idleCycle();
    @(posedge iCLK);
    #1;
    iDVAL = 1'b0;
  endtask

  task automatic drainOutputs();
    for (int i = 0; i < 50 && expVal.size() > 0; i++) @(posedge iCLK);
    repeat (2) @(posedge iCLK);
    checkOutput("drain pending", expVal.size(), 0);
    expVal.delete(); expCyc.delete(); expGx.delete(); expGy.delete();
  endtask

  task automatic sendFrame(input int mode, input int midMode, input int maxGap);
    modelMode = mode;
    pulseCount = 0;
    seqOut.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) dutOut[r][c] = -1;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int gaps;
        applyStimulus(x, y, (midMode >= 0 && y >= 4) ? midMode : mode);
        gaps = (maxGap > 0) ? int'($urandom_range(maxGap, 1)) : 0;
        repeat (gaps) idleCycle();
      end
    end
    idleCycle();
    drainOutputs();
    checkOutput("pulse count", pulseCount, 16);
  endtask

  task automatic fillRandom();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) rawImg[y][x] = int'($urandom_range(4095, 0));
  endtask

  task automatic fillConst(input int v);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) rawImg[y][x] = v;
  endtask

  task automatic fillEdge(input int level);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) rawImg[y][x] = (x >= 4) ? level : 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRST = 1'b0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0; iDATA = '0; iMODE = 2'd0;
    repeat (3) @(posedge iCLK);
    #2;
    checkOutput("reset oDVAL", int'(oDVAL), 0);
    checkOutput("reset oRed", int'(oRed), 0);
    iRST = 1'b1;
    monitorOn = 1'b1;

    $display("[TB] bypass quad 4/8/12/16");
    fillRandom();
    rawImg[2][2] = 4; rawImg[2][3] = 8; rawImg[3][2] = 12; rawImg[3][3] = 16;
    checkOutput("model grey(1,1)", greyAt(1, 1), 10);
    sendFrame(0, -1, 0);
    checkOutput("bypass slot(2,2)", dutOut[2][2], 10);

    $display("[TB] flat frame, magnitude");
    fillConst(100);
    sendFrame(3, -1, 0);
    checkOutput("flat slot(3,3)", dutOut[3][3], 0);

    $display("[TB] vertical edge 0/1000");
    fillEdge(1000);
    checkOutput("model edge gx", expectedOut(2, 2, 1), 4000);
    checkOutput("model edge gy", expectedOut(2, 2, 2), 0);
    sendFrame(1, -1, 0);
    checkOutput("edge gx slot(2,2)", dutOut[2][2], 4000);
    checkOutput("edge gx slot(3,2)", dutOut[2][3], 4000);
    seqRef = seqOut;
    sendFrame(2, -1, 0);
    checkOutput("edge gy slot(2,2)", dutOut[2][2], 0);
    sendFrame(3, -1, 0);
    checkOutput("edge mag slot(2,2)", dutOut[2][2], 4000);

    $display("[TB] saturation edge 0/4095");
    fillEdge(4095);
    checkOutput("model saturation", expectedOut(3, 3, 1), 4095);
    sendFrame(1, -1, 0);
    checkOutput("sat slot(2,2)", dutOut[2][2], 4095);
    checkOutput("border slot(2,1)", dutOut[1][2], 0);
    checkOutput("border slot(1,3)", dutOut[3][1], 0);

    $display("[TB] edge with random iDVAL gaps");
    fillEdge(1000);
    sendFrame(1, -1, 5);
    checkOutput("gap seq length", seqOut.size(), seqRef.size());
    for (int i = 0; i < seqRef.size() && i < seqOut.size(); i++)
      checkOutput("gap seq value", seqOut[i], seqRef[i]);

    $display("[TB] mid-frame mode change then next frame");
    fillRandom();
    sendFrame(1, 2, 0);
    fillRandom();
    sendFrame(2, -1, 2);

    $display("[TB] reset mid-line");
    fillRandom();
    monitorOn = 1'b0;
    pushExp = 1'b0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 8 && !(y == 4 && x > 3); x++) applyStimulus(x, y, 1);
    #2;
    iRST = 1'b0;
    iDVAL = 1'b0;
    #1;
    checkOutput("mid reset oDVAL", int'(oDVAL), 0);
    checkOutput("mid reset oRed", int'(oRed), 0);
    checkOutput("mid reset oGreen", int'(oGreen), 0);
    checkOutput("mid reset oBlue", int'(oBlue), 0);
    checkOutput("mid reset mode", int'(dut.modeQ), 2);
    repeat (2) @(posedge iCLK);
    #3;
    iRST = 1'b1;
    expVal.delete(); expCyc.delete(); expGx.delete(); expGy.delete();
    lastExp = 0;
    pushExp = 1'b1;
    monitorOn = 1'b1;
    fillRandom();
    sendFrame(3, -1, 2);
    fillRandom();
    sendFrame(0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
